// File: rtl/led_pattern_if.sv
// Switch/duty inputs and LED/blink outputs of led_pattern_ctrl, grouped as one bundle.
// No handshake: every signal is level-sampled on each clock edge.
interface led_pattern_if #(
    parameter int NUM_LED  = 4,
    parameter int PWM_BITS = 4
);
    logic [2*NUM_LED-1:0] s;
    logic [PWM_BITS-1:0]  duty;
    logic [NUM_LED-1:0]   led;
    logic                 blink_phase;

    modport master (output s, output duty, input led, input blink_phase);
    modport slave  (input s, input duty, output led, output blink_phase);
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: synchronised, debounced 2-bit mode per channel selecting off/on/blink/PWM.
// Optional macro PHASE_STAGGER_EN inverts the blink phase on odd-indexed channels.
module led_pattern_ctrl #(
    parameter int NUM_LED         = 4,
    parameter int BLINK_DIV       = 5000000,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int PWM_BITS        = 4
) (
    input  logic         clk,
    input  logic         reset,
    led_pattern_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [2*NUM_LED-1:0] sync1;
    logic [2*NUM_LED-1:0] s_sync;
    logic [1:0]           mode_q [NUM_LED];
    logic [DBW-1:0]       db_cnt [NUM_LED];
    logic [BW-1:0]        blink_cnt;
    logic                 blink_phase_q;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [PWM_BITS-1:0]  duty_q;
    logic                 pwm_on;
    logic [NUM_LED-1:0]   led_d;
    logic [NUM_LED-1:0]   led_q;

    // Stability is judged against the stage behind s_sync, so the cycle a new
    // value lands in s_sync already counts toward the window: 2 + D + 1 edges end to end.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            s_sync <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                mode_q[i] <= 2'b00;
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= bus.s;
            s_sync <= sync1;
            for (int i = 0; i < NUM_LED; i++) begin
                if ((s_sync[2*i +: 2] == mode_q[i]) || (s_sync[2*i +: 2] != sync1[2*i +: 2])) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    mode_q[i] <= s_sync[2*i +: 2];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Free-running prescaler shared by all channels keeps blinkers in phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt     <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt     <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Duty is captured only at the period boundary so a period is never split.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == {PWM_BITS{1'b1}}) begin
                duty_q <= bus.duty;
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty_q);

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (mode_q[i])
                2'b00: led_d[i] = 1'b0;
                2'b01: led_d[i] = 1'b1;
`ifdef PHASE_STAGGER_EN
                2'b10: led_d[i] = ((i % 2) != 0) ? ~blink_phase_q : blink_phase_q;
`else
                2'b10: led_d[i] = blink_phase_q;
`endif
                default: led_d[i] = pwm_on;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign bus.led         = led_q;
    assign bus.blink_phase = blink_phase_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with NUM_LED=4, BLINK_DIV=4, DEBOUNCE_CYCLES=8, PWM_BITS=3.
// n counts edges since the last reset edge; expectations are derived from n by hand-worked rules.
module tb_led_pattern_ctrl;
  logic clk;
  logic reset;
  int   n;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  led_pattern_if #(.NUM_LED(4), .PWM_BITS(3)) bus ();

  led_pattern_ctrl #(
    .NUM_LED(4),
    .BLINK_DIV(4),
    .DEBOUNCE_CYCLES(8),
    .PWM_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (n=%0d): got %0h expected %0h", tag, n, act, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset(input logic [7:0] sv, input logic [2:0] dv);
    reset    = 1'b1;
    bus.s    = sv;
    bus.duty = dv;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // blink_phase value right after edge k (toggles on edges 4, 8, 12, ...)
  function automatic logic phase_after(input int k);
    return ((k / 4) % 2) == 1;
  endfunction

  function automatic logic [3:0] pwm_exp(input int cnt, input int d);
    return (cnt < d) ? 4'hF : 4'h0;
  endfunction

  // old_d applies to led after edge n while duty_q(n-1) is old, i.e. n-1 < load_n
  task automatic pwm_run(input int count, input int old_d, input int new_d, input int load_n);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      check("pwm", bus.led, pwm_exp((n - 1) % 8, ((n - 1) >= load_n) ? new_d : old_d));
    end
  endtask

  initial begin
    logic       p;
    logic [3:0] e;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.s    = 8'hFF;
    bus.duty = 3'd0;

    // reset state and exact acceptance latency
    repeat (2) @(negedge clk);
    check("reset_led", bus.led, 8'h0);
    check("reset_phase", bus.blink_phase, 8'h0);
    reset = 1'b0;
    bus.s = 8'h55;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("latency", bus.led, (k < 11) ? 8'h0 : 8'hF);
    end

    // bounce on channel 0, then hold blink
    apply_reset(8'h00, 3'd0);
    for (int c = 0; c < 30; c++) begin
      bus.s = (((c / 3) % 2) == 0) ? 8'h02 : 8'h00;
      @(negedge clk);
      check("bounce", bus.led[0], 8'h0);
    end
    bus.s = 8'h02;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      check("bounce_hold", bus.led[0], (k < 11) ? 8'h0 : 8'(phase_after(n - 1)));
      if ((k % 5) == 0) check("phase", bus.blink_phase, 8'(phase_after(n)));
    end

    // PWM duty sweep; duty_q loads on edges 8, 16, ...
    apply_reset(8'hFF, 3'd3);
    repeat (10) @(negedge clk);
    pwm_run(16, 3, 3, 8);
    bus.duty = 3'd0;
    pwm_run(14, 3, 0, 32);
    bus.duty = 3'd7;
    pwm_run(16, 0, 7, 48);

    // all channels blinking, scoreboard-driven
    apply_reset(8'hAA, 3'd0);
    repeat (10) @(negedge clk);
    for (int m = 11; m <= 26; m++) begin
      p = phase_after(m - 1);
`ifdef PHASE_STAGGER_EN
      e = p ? 4'b0101 : 4'b1010;
`else
      e = {4{p}};
`endif
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("blink", bus.led, exp_q.pop_front());
    end

    // reset mid-blink, mid-PWM and mid-debounce
    apply_reset(8'h0E, 3'd5);
    repeat (20) @(negedge clk);
    bus.s = 8'h1E;
    repeat (5) @(negedge clk);
    apply_reset(8'h1E, 3'd5);
    check("midreset_led", bus.led, 8'h0);
    check("midreset_phase", bus.blink_phase, 8'h0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("midreset_relatch", bus.led, (k < 11) ? 8'h0 : 8'h6);
    end

    // channel 1: 00 -> 01 -> 11 after 4 cycles; only 11 may be accepted
    apply_reset(8'h04, 3'd4);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("third_value", bus.led[1], (k < 15) ? 8'h0 : 8'(((k - 1) % 8) < 4));
      if (k == 4) bus.s = 8'h0C;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
